inner_product_checker: RTL

- Consumer end of the inner-product test interface.
- Accepts one transaction: operand vectors a and b plus the DUT-reported result. Recomputes the inner product serially, one multiply-accumulate per cycle, then compares against the reported result.
- Reports pass/fail per transaction and keeps saturating check and error counters, so self-checking needs no simulator $display inspection.
- Sits beside inner_product_test. Both vector ports are driven from the packed inps bus when checking a self-product.

---
 rtl/inner_product_pkg.sv | 33 +++
 rtl/inner_product_checker_sat_counter.sv | 20 ++
 rtl/inner_product_checker.sv | 113 +++++++++++
 3 files changed

// File: rtl/inner_product_pkg.sv
// Shared definitions for the inner-product checker: FSM encoding,
// accumulator sizing and packed-vector element extraction.
package inner_product_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t ACC  = 2'd1;
  localparam state_t CMP  = 2'd2;

  // Upper bounds for the generic element extractor; callers cast their
  // vectors to these widths and the result back to their element width.
  localparam int MAX_VEC_W  = 1024;
  localparam int MAX_ELEM_W = 32;

  // Width that holds a full sum of num_elems products without overflow.
  function automatic int acc_width(input int dw, input int n);
    int w;
    w = 2 * dw + $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

  // Element i of a packed vector whose elements are dw bits wide.
  function automatic logic [MAX_ELEM_W-1:0] elem_of(input logic [MAX_VEC_W-1:0] vec,
                                                    input int i, input int dw);
    logic [MAX_VEC_W-1:0]  sh;
    logic [MAX_ELEM_W-1:0] mask;
    sh   = vec >> (i * dw);
    mask = (dw >= MAX_ELEM_W) ? '1 : ((MAX_ELEM_W'(1) << dw) - MAX_ELEM_W'(1));
    return sh[MAX_ELEM_W-1:0] & mask;
  endfunction

endpackage

// File: rtl/inner_product_checker_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int width = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [width-1:0] count
);

  // Count increments until the counter is full, then hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + width'(1);
    end
  end

endmodule

// File: rtl/inner_product_checker.sv
// Consumer end of the inner-product test interface: captures one
// transaction, recomputes the inner product one MAC per cycle and
// reports a pass/fail verdict plus saturating check/error counts.
module inner_product_checker
  import inner_product_pkg::*;
#(
  parameter int data_width = 2,
  parameter int num_elems  = 2,
  parameter int outp_width = 8,
  parameter int cnt_width  = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [num_elems*data_width-1:0] vec_a,
  input  logic [num_elems*data_width-1:0] vec_b,
  input  logic [outp_width-1:0]           result,
  output logic                            done,
  output logic                            pass,
  output logic [outp_width-1:0]           expected,
  output logic [cnt_width-1:0]            check_count,
  output logic [cnt_width-1:0]            err_count
);

  localparam int VEC_W = num_elems * data_width;
  localparam int ACC_W = acc_width(data_width, num_elems);
  localparam int IDX_W = (num_elems > 1) ? $clog2(num_elems) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(num_elems - 1);

  state_t                  state;
  logic [VEC_W-1:0]        a_cap;
  logic [VEC_W-1:0]        b_cap;
  logic [outp_width-1:0]   res_cap;
  logic [ACC_W-1:0]        acc;
  logic [IDX_W-1:0]        idx;

  logic [data_width-1:0]   a_elem;
  logic [data_width-1:0]   b_elem;
  logic [ACC_W-1:0]        prod;
  logic [outp_width-1:0]   acc_trunc;
  logic                    finishing;
  logic                    mismatch;

  assign in_ready  = (state == IDLE);
  assign a_elem    = data_width'(elem_of(MAX_VEC_W'(a_cap), int'(idx), data_width));
  assign b_elem    = data_width'(elem_of(MAX_VEC_W'(b_cap), int'(idx), data_width));
  // Operands are widened before multiplying so the product is never truncated.
  assign prod      = ACC_W'(a_elem) * ACC_W'(b_elem);
  // Comparison is modulo 2^outp_width; the cast truncates or zero-extends.
  assign acc_trunc = outp_width'(acc);
  assign finishing = (state == CMP);
  assign mismatch  = finishing && (acc_trunc != res_cap);

  // Capture / multiply-accumulate / compare sequencer with held verdict.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      a_cap    <= '0;
      b_cap    <= '0;
      res_cap  <= '0;
      acc      <= '0;
      idx      <= '0;
      done     <= 1'b0;
      pass     <= 1'b0;
      expected <= '0;
    end else begin
      // done marks the first IDLE cycle after a compare and nothing else.
      done <= finishing;
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_cap   <= vec_a;
            b_cap   <= vec_b;
            res_cap <= result;
            acc     <= '0;
            idx     <= '0;
            state   <= ACC;
          end
        end
        ACC: begin
          acc <= acc + prod;
          if (idx == LAST_IDX) begin
            state <= CMP;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        CMP: begin
          expected <= acc_trunc;
          pass     <= (acc_trunc == res_cap);
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  sat_counter #(.width(cnt_width)) u_check_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (finishing),
    .count (check_count)
  );

  sat_counter #(.width(cnt_width)) u_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (mismatch),
    .count (err_count)
  );

endmodule
